// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-master to one-slave AXI read arbiter, one burst in flight
module axi_read_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int IDS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   ARID_M0,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M0,
  input  logic [LEN_WIDTH-1:0]  ARLEN_M0,
  input  logic [2:0]            ARSIZE_M0,
  input  logic [1:0]            ARBURST_M0,
  input  logic                  ARVALID_M0,
  output logic                  ARREADY_M0,
  output logic [ID_WIDTH-1:0]   RID_M0,
  output logic [DATA_WIDTH-1:0] RDATA_M0,
  output logic [1:0]            RRESP_M0,
  output logic                  RLAST_M0,
  output logic                  RVALID_M0,
  input  logic                  RREADY_M0,
  input  logic [ID_WIDTH-1:0]   ARID_M1,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M1,
  input  logic [LEN_WIDTH-1:0]  ARLEN_M1,
  input  logic [2:0]            ARSIZE_M1,
  input  logic [1:0]            ARBURST_M1,
  input  logic                  ARVALID_M1,
  output logic                  ARREADY_M1,
  output logic [ID_WIDTH-1:0]   RID_M1,
  output logic [DATA_WIDTH-1:0] RDATA_M1,
  output logic [1:0]            RRESP_M1,
  output logic                  RLAST_M1,
  output logic                  RVALID_M1,
  input  logic                  RREADY_M1,
  output logic [IDS_WIDTH-1:0]  ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [LEN_WIDTH-1:0]  ARLEN_S,
  output logic [2:0]            ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  input  logic [IDS_WIDTH-1:0]  RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam int PAD_WIDTH = IDS_WIDTH - ID_WIDTH - 1;

  logic [1:0] state, state_nxt;
  logic       gnt, gnt_nxt;
  logic       prio, prio_nxt;

  logic                  in_addr, in_data;
  logic [ID_WIDTH-1:0]   arid_g;
  logic [ADDR_WIDTH-1:0] araddr_g;
  logic [LEN_WIDTH-1:0]  arlen_g;
  logic [2:0]            arsize_g;
  logic [1:0]            arburst_g;
  logic                  arvalid_g;
  logic                  rready_g;
  logic                  r_to_m0, r_to_m1;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      prio  <= prio_nxt;
    end
  end

  // Requests from the other master are not looked at again until the burst ends.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (ARVALID_M0 && ARVALID_M1) begin
          gnt_nxt   = prio;
          state_nxt = ADDR;
        end else if (ARVALID_M0) begin
          gnt_nxt   = 1'b0;
          state_nxt = ADDR;
        end else if (ARVALID_M1) begin
          gnt_nxt   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_g && ARREADY_S) state_nxt = DATA;
      end
      DATA: begin
        if (RVALID_S && RREADY_S && RLAST_S) begin
          state_nxt = IDLE;
          prio_nxt  = ~gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);

  assign arid_g    = gnt ? ARID_M1    : ARID_M0;
  assign araddr_g  = gnt ? ARADDR_M1  : ARADDR_M0;
  assign arlen_g   = gnt ? ARLEN_M1   : ARLEN_M0;
  assign arsize_g  = gnt ? ARSIZE_M1  : ARSIZE_M0;
  assign arburst_g = gnt ? ARBURST_M1 : ARBURST_M0;
  assign arvalid_g = gnt ? ARVALID_M1 : ARVALID_M0;
  assign rready_g  = gnt ? RREADY_M1  : RREADY_M0;

  // Master index sits just above the master ID so responses can be routed back.
  assign ARID_S    = in_addr ? {{PAD_WIDTH{1'b0}}, gnt, arid_g} : '0;
  assign ARADDR_S  = in_addr ? araddr_g  : '0;
  assign ARLEN_S   = in_addr ? arlen_g   : '0;
  assign ARSIZE_S  = in_addr ? arsize_g  : '0;
  assign ARBURST_S = in_addr ? arburst_g : '0;
  assign ARVALID_S = in_addr & arvalid_g;

  assign ARREADY_M0 = in_addr & ~gnt & ARREADY_S;
  assign ARREADY_M1 = in_addr &  gnt & ARREADY_S;

  assign RREADY_S = in_data & rready_g;
  assign r_to_m0  = in_data & ~gnt;
  assign r_to_m1  = in_data &  gnt;

  assign RID_M0    = r_to_m0 ? RID_S[ID_WIDTH-1:0] : '0;
  assign RDATA_M0  = r_to_m0 ? RDATA_S : '0;
  assign RRESP_M0  = r_to_m0 ? RRESP_S : '0;
  assign RLAST_M0  = r_to_m0 & RLAST_S;
  assign RVALID_M0 = r_to_m0 & RVALID_S;

  assign RID_M1    = r_to_m1 ? RID_S[ID_WIDTH-1:0] : '0;
  assign RDATA_M1  = r_to_m1 ? RDATA_S : '0;
  assign RRESP_M1  = r_to_m1 ? RRESP_S : '0;
  assign RLAST_M1  = r_to_m1 & RLAST_S;
  assign RVALID_M1 = r_to_m1 & RVALID_S;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - directed scoreboard bench for axi_read_arbiter
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, RID_M0, RID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1, RDATA_M0, RDATA_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1, RRESP_M0, RRESP_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S, RID_S;
  logic [31:0] ARADDR_S, RDATA_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S, RRESP_S;
  logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

  int total = 0;
  int bad   = 0;
  logic [39:0] ar_q[$];
  logic [38:0] r_q[$];

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    if (m == 0) begin
      ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1; ARVALID_M0 = 1'b1;
    end else begin
      ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1; ARVALID_M1 = 1'b1;
    end
    ar_q.push_back({3'b000, m[0], id, addr});
  endtask

  // Waits for the slave AR request, holds ARREADY_S low for 'stall' cycles, then accepts it.
  task automatic ar_phase(input int m, input int exp_lat, input int stall);
    int n;
    logic [39:0] e;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!ARVALID_S && n < 40);
    if (!ARVALID_S) begin
      check("ar_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_lat > 0) check("ar_latency", n, exp_lat);
    e = ar_q.pop_front();
    check("arid_s", ARID_S, e[39:32]);
    check("araddr_s", ARADDR_S, e[31:0]);
    repeat (stall) begin
      check("stall_arvalid_s", ARVALID_S, 1);
      check("stall_araddr_s", ARADDR_S, e[31:0]);
      check("stall_arready_m", (m == 1) ? ARREADY_M1 : ARREADY_M0, 0);
      @(negedge ACLK);
    end
    ARREADY_S = 1'b1;
    #1;
    check("arready_granted", (m == 1) ? ARREADY_M1 : ARREADY_M0, 1);
    check("arready_other", (m == 1) ? ARREADY_M0 : ARREADY_M1, 0);
    @(posedge ACLK);
    #1;
    ARREADY_S = 1'b0;
    if (m == 1) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
  endtask

  // Acts as the slave R channel; pat gives the master's RREADY per cycle.
  task automatic r_phase(input int m, input int nb, input logic [3:0] id, input logic [31:0] base,
                         input logic [7:0] pat, input int abort);
    int k, cyc;
    bit pushed, rdy;
    logic [38:0] e;
    k = 0; cyc = 0; pushed = 0;
    while (k < nb && cyc < 40) begin
      if (abort > 0 && k == abort) break;
      rdy = pat[cyc % 8];
      RVALID_S = 1'b1;
      RDATA_S  = base + k;
      RID_S    = {3'b000, m[0], id};
      RRESP_S  = k[1:0];
      RLAST_S  = (k == nb - 1);
      if (m == 1) RREADY_M1 = rdy; else RREADY_M0 = rdy;
      if (!pushed) begin
        r_q.push_back({RLAST_S, RRESP_S, id, base + k});
        pushed = 1;
      end
      @(negedge ACLK);
      check("rvalid_granted", (m == 1) ? RVALID_M1 : RVALID_M0, 1);
      check("rvalid_other", (m == 1) ? RVALID_M0 : RVALID_M1, 0);
      check("rdata_other", (m == 1) ? RDATA_M0 : RDATA_M1, 0);
      check("rready_s", RREADY_S, rdy);
      if (rdy) begin
        e = r_q.pop_front();
        check("rdata", (m == 1) ? RDATA_M1 : RDATA_M0, e[31:0]);
        check("rid", (m == 1) ? RID_M1 : RID_M0, e[35:32]);
        check("rresp", (m == 1) ? RRESP_M1 : RRESP_M0, e[37:36]);
        check("rlast", (m == 1) ? RLAST_M1 : RLAST_M0, e[38]);
        k++;
        pushed = 0;
      end
      @(posedge ACLK);
      #1;
      cyc++;
    end
    if (abort == 0) begin
      check("beats_delivered", k, nb);
      RLAST_S = 1'b0; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
      @(negedge ACLK);
      check("idle_after_last_m0", RVALID_M0, 0);
      check("idle_after_last_m1", RVALID_M1, 0);
      @(posedge ACLK);
      #1;
      RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 1'b0;
    ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 1'b0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0; ARREADY_S = 1'b0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;

    // reset state, with slave R inputs active to expose leaks
    RVALID_S = 1'b1; RDATA_S = 32'h5555_AAAA;
    @(negedge ACLK);
    check("rst_arvalid_s", ARVALID_S, 0);
    check("rst_rready_s", RREADY_S, 0);
    check("rst_arready_m0", ARREADY_M0, 0);
    check("rst_arready_m1", ARREADY_M1, 0);
    check("rst_rvalid_m0", RVALID_M0, 0);
    check("rst_rvalid_m1", RVALID_M1, 0);
    check("rst_rdata_m0", RDATA_M0, 0);
    @(posedge ACLK);
    #1;
    RVALID_S = 1'b0; RDATA_S = '0;

    // M0 alone, single beat
    request(0, 4'h3, 32'h0000_1000, 4'd0);
    ar_phase(0, 2, 0);
    r_phase(0, 1, 4'h3, 32'hDEAD_BEEF, 8'hFF, 0);

    // M1 alone, 4 beats with RREADY 1,0,1,1,1
    request(1, 4'h5, 32'h0000_2000, 4'd3);
    ar_phase(1, 2, 0);
    r_phase(1, 4, 4'h5, 32'hB100_0000, 8'b1111_1101, 0);

    // simultaneous requests twice: M0, M1, M0, M1
    for (int i = 0; i < 2; i++) begin
      request(0, 4'h1, 32'h0000_3000 + i, 4'd1);
      request(1, 4'h9, 32'h0000_4000 + i, 4'd0);
      ar_phase(0, 2, 0);
      r_phase(0, 2, 4'h1, 32'hC000_0000 + (i << 8), 8'hFF, 0);
      ar_phase(1, 0, 0);
      r_phase(1, 1, 4'h9, 32'hC100_0000 + (i << 8), 8'hFF, 0);
    end

    // M0 with ARREADY_S held low 5 cycles
    request(0, 4'h7, 32'h0000_5000, 4'd1);
    ar_phase(0, 2, 5);
    r_phase(0, 2, 4'h7, 32'hD000_0000, 8'hFF, 0);

    // M1 burst of 4 abandoned by reset after beat 2
    request(1, 4'h2, 32'h0000_6000, 4'd3);
    ar_phase(1, 2, 0);
    r_phase(1, 4, 4'h2, 32'hE000_0000, 8'hFF, 2);
    RVALID_S = 1'b1; RLAST_S = 1'b0; RREADY_M1 = 1'b1; RREADY_M0 = 1'b1;
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("pre_reset_rvalid_m1", RVALID_M1, 1);
    @(negedge ACLK);
    check("post_reset_rvalid_m0", RVALID_M0, 0);
    check("post_reset_rvalid_m1", RVALID_M1, 0);
    check("post_reset_arvalid_s", ARVALID_S, 0);
    check("post_reset_rready_s", RREADY_S, 0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    RVALID_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    r_q.delete();

    // priority back at M0 after reset
    request(0, 4'hA, 32'h0000_7000, 4'd0);
    request(1, 4'hB, 32'h0000_8000, 4'd0);
    ar_phase(0, 2, 0);
    r_phase(0, 1, 4'hA, 32'hF000_0000, 8'hFF, 0);
    ar_phase(1, 0, 0);
    r_phase(1, 1, 4'hB, 32'hF100_0000, 8'hFF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have parameters: ID_WIDTH = 4 (master ID width), IDS_WIDTH = 8 (slave-side ID width), ADDR_WIDTH = 32 (address width), DATA_WIDTH = 32 (data width), LEN_WIDTH = 4 (burst length width).
REQ-002 The block SHALL have these ports, clock and reset first:
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- ARID_Mx  in  ID_WIDTH  master x read ID (x = 0, 1).
- ARADDR_Mx  in  ADDR_WIDTH  master x read address.
- ARLEN_Mx  in  LEN_WIDTH  master x burst length.
- ARSIZE_Mx  in  3  master x burst size.
- ARBURST_Mx  in  2  master x burst type.
- ARVALID_Mx  in  1  master x address valid.
- ARREADY_Mx  out  1  address ready to master x.
- RID_Mx  out  ID_WIDTH  read ID to master x.
- RDATA_Mx  out  DATA_WIDTH  read data to master x.
- RRESP_Mx  out  2  read response to master x.
- RLAST_Mx  out  1  last beat to master x.
- RVALID_Mx  out  1  read valid to master x.
- RREADY_Mx  in  1  master x read ready.
- ARID_S  out  IDS_WIDTH  slave ID.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S  out  as master side  slave AR channel.
- ARREADY_S  in  1  slave address ready.
- RID_S  in  IDS_WIDTH  slave read ID.
- RDATA_S, RRESP_S, RLAST_S, RVALID_S  in  as master side  slave R channel.
- RREADY_S  out  1  slave read ready.

Function
REQ-003 The block SHALL implement a 3-state FSM: IDLE, ADDR, DATA.
REQ-004 State register and grant register (GNT, 1 bit) SHALL update only on ACLK rising edge.
REQ-005 IDLE: ARVALID_S, RREADY_S, all ARREADY_Mx and RVALID_Mx = 0.
REQ-006 IDLE, one ARVALID_Mx high: GNT <= x; next state ADDR.
REQ-007 IDLE, both high: GNT <= master holding priority (PRIO register); next state ADDR.
REQ-008 IDLE, none high: stay IDLE.
REQ-009 ADDR: ARADDR/ARLEN/ARSIZE/ARBURST_S = granted master's fields (combinational pass-through).
REQ-010 ADDR: ARVALID_S = ARVALID of granted master; ARREADY_M[GNT] = ARREADY_S; other master's ARREADY = 0.
REQ-011 ADDR: ARID_S = {(IDS_WIDTH-ID_WIDTH-1) zeros, GNT, ARID_M[GNT]}.
REQ-012 ADDR, ARVALID_S & ARREADY_S: next state DATA; else stay ADDR.
REQ-013 DATA: RID/RDATA/RRESP/RLAST_M[GNT] = RID_S[ID_WIDTH-1:0]/RDATA_S/RRESP_S/RLAST_S.
REQ-014 DATA: RVALID_M[GNT] = RVALID_S; RREADY_S = RREADY_M[GNT]; non-granted RVALID = 0; all ARREADY_Mx = 0.
REQ-015 DATA, RVALID_S & RREADY_S & RLAST_S: next state IDLE; PRIO <= ~GNT (round-robin).
REQ-016 DATA, beat without RLAST: stay DATA, no beat count, no timeout.
REQ-017 At most one outstanding burst; AR latency master->slave = 1 cycle after IDLE arbitration.
REQ-018 Non-granted master's ARVALID SHALL be ignored until return to IDLE; no master starves (at most one foreign burst between requests).
REQ-019 Non-granted master's R outputs SHALL be 0 whenever not in DATA with GNT pointing to it.

Reset
REQ-020 ARESETn = 0 at an ACLK edge: state <= IDLE, GNT <= 0, PRIO <= 0 (M0 first).
REQ-021 Reset SHALL take effect mid-burst: all outputs 0 from the next cycle; the in-flight burst is abandoned.

Verification
REQ-022 M0 only, ARADDR_M0=0x0000_1000, ARID_M0=0x3, ARLEN=0 -> ARID_S=0x03, ARADDR_S=0x1000; RDATA_S=0xDEADBEEF, RID_S=0x03, RLAST=1 -> RDATA_M0=0xDEADBEEF, RID_M0=0x3, RVALID_M1=0.
REQ-023 M0 and M1 assert in the same cycle after reset -> M0 granted first (ARID_S bit4=0), then M1 (ARID_S=0x10|ARID_M1); third simultaneous request -> M0.
REQ-024 M1 burst ARLEN=3 with RREADY_M1 toggling 1,0,1,1,1 -> exactly 4 beats delivered to M1 in order; FSM returns to IDLE only after the RLAST beat.
REQ-025 ARREADY_S held low 5 cycles -> ARVALID_S stays 1 and address stable; ARREADY_M[GNT]=0 throughout.
REQ-026 ARESETn low during DATA after beat 2 of 4 -> next cycle all RVALID_Mx=0, ARVALID_S=0, RREADY_S=0; PRIO=M0.
